// File: rtl/pipeline_exec_ctrl_pkg.sv
// Shared types and helpers for the pipeline execution controller.
//
// Contents:
//   cmd_e        : debug-unit command codes (RUN, STEP, STOP, CLEAR)
//   state_e      : controller state encodings, visible on state_o
//   acceptsCmd   : states in which a command handshake can complete
//   pipeEnabled  : states in which the pipeline registers advance
package pipeline_exec_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_DONE      = 3'd4,
    ST_FLUSH     = 3'd5
  } state_e;

  // STEP_EXEC and FLUSH are transient, so commands are held off there
  function automatic logic acceptsCmd(input state_e s);
    return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_STEP_WAIT) || (s == ST_DONE);
  endfunction

  function automatic logic pipeEnabled(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP_EXEC);
  endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//
// Ports:
//   i_clock  : clock, counts on posedge
//   i_reset  : synchronous active-high reset to zero
//   i_clear  : synchronous clear to zero, wins over i_inc
//   i_inc    : add one this cycle unless already at all-ones
//   o_count  : current count
module pipeline_exec_ctrl_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Holds at all-ones instead of wrapping so a long run never reads as short
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Execution controller for the MIPS pipeline. Drives the shared enable for
// every stage register, a multi-cycle flush pulse, and the run/step/stop
// sequencing requested by the debug unit. Execution ends when the halt
// marker reaches writeback or the enabled-cycle budget runs out.
//
// Ports:
//   clock_i        : system clock, all state on posedge
//   reset_i        : synchronous active-high reset
//   cmd_valid_i    : command present
//   cmd_i          : RUN=00 STEP=01 STOP=10 CLEAR=11
//   cmd_ready_o    : command taken when valid and ready at posedge
//   halt_wb_i      : halt marker seen at MEM/WB output
//   enable_pipe_o  : advance enable for all pipeline registers
//   pipe_flush_o   : flush pulse, FLUSH_CYCLES long
//   state_o        : current state encoding
//   halted_o       : run ended by halt instruction
//   timeout_o      : run ended by MAX_CYCLES budget
//   cycle_count_o  : enabled cycles since last CLEAR/reset, saturating
module pipeline_exec_ctrl
  import pipeline_exec_ctrl_pkg::*;
#(
  parameter int          NB_CNT       = 32,
  parameter int unsigned MAX_CYCLES   = 0,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  input  logic [1:0]        cmd_i,
  output logic              cmd_ready_o,
  input  logic              halt_wb_i,
  output logic              enable_pipe_o,
  output logic              pipe_flush_o,
  output logic [2:0]        state_o,
  output logic              halted_o,
  output logic              timeout_o,
  output logic [NB_CNT-1:0] cycle_count_o
);

  localparam int NB_FLUSH = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [NB_CNT:0] BUDGET  = (NB_CNT+1)'(MAX_CYCLES);
  localparam logic [NB_CNT:0] CNT_ONE = (NB_CNT+1)'(1);

  state_e            r_state;
  logic              r_halted;
  logic              r_timeout;

  cmd_e              w_cmd;
  logic              w_cmdReady;
  logic              w_accept;
  logic              w_enable;
  logic [NB_CNT-1:0] w_count;
  logic              w_budgetHit;
  logic [NB_FLUSH-1:0] w_flushCnt;
  logic              w_inFlush;
  logic              w_flushLast;
  logic              w_enterFlush;

  assign w_cmd      = cmd_e'(cmd_i);
  assign w_cmdReady = acceptsCmd(r_state);
  assign w_accept   = cmd_valid_i && w_cmdReady;
  assign w_enable   = pipeEnabled(r_state);
  assign w_inFlush  = (r_state == ST_FLUSH);

  // Budget is judged on the count this enabled edge will produce, one bit
  // wider so an all-ones count cannot alias back to a small budget
  assign w_budgetHit = (MAX_CYCLES != 0) && (({1'b0, w_count} + CNT_ONE) == BUDGET);

  assign w_flushLast = w_inFlush && (w_flushCnt == NB_FLUSH'(FLUSH_CYCLES - 1));

  // In RUN a halt or budget expiry outranks CLEAR, so CLEAR only flushes
  // when neither end condition fires on the same edge
  assign w_enterFlush = w_accept && (w_cmd == CMD_CLEAR) &&
                        !((r_state == ST_RUN) && (halt_wb_i || w_budgetHit));

  // Clearing on flush entry beats the increment from a RUN cycle ending here
  pipeline_exec_ctrl_sat_counter #(.WIDTH(NB_CNT)) u_cycleCounter (
    .i_clock (clock_i),
    .i_reset (reset_i),
    .i_clear (w_enterFlush),
    .i_inc   (w_enable),
    .o_count (w_count)
  );

  // Counts position within the flush pulse and rearms itself on the last cycle
  pipeline_exec_ctrl_sat_counter #(.WIDTH(NB_FLUSH)) u_flushCounter (
    .i_clock (clock_i),
    .i_reset (reset_i),
    .i_clear (w_flushLast),
    .i_inc   (w_inFlush),
    .o_count (w_flushCnt)
  );

  // Main sequencer; halt is checked before the budget so a coincident halt
  // is reported as a halt, and STEP_WAIT deliberately ignores halt_wb_i
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_enterFlush) begin
        r_halted  <= 1'b0;
        r_timeout <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_cmd)
              CMD_RUN:   r_state <= ST_RUN;
              CMD_STEP:  r_state <= ST_STEP_EXEC;
              CMD_CLEAR: r_state <= ST_FLUSH;
              default:   r_state <= ST_IDLE;
            endcase
          end
        end
        ST_RUN: begin
          if (halt_wb_i) begin
            r_state  <= ST_DONE;
            r_halted <= 1'b1;
          end else if (w_budgetHit) begin
            r_state   <= ST_DONE;
            r_timeout <= 1'b1;
          end else if (w_accept && (w_cmd == CMD_STOP)) begin
            r_state <= ST_STEP_WAIT;
          end else if (w_accept && (w_cmd == CMD_CLEAR)) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_STEP_WAIT: begin
          if (w_accept) begin
            case (w_cmd)
              CMD_STEP:  r_state <= ST_STEP_EXEC;
              CMD_RUN:   r_state <= ST_RUN;
              CMD_CLEAR: r_state <= ST_FLUSH;
              default:   r_state <= ST_STEP_WAIT;
            endcase
          end
        end
        ST_STEP_EXEC: begin
          if (halt_wb_i) begin
            r_state  <= ST_DONE;
            r_halted <= 1'b1;
          end else if (w_budgetHit) begin
            r_state   <= ST_DONE;
            r_timeout <= 1'b1;
          end else begin
            r_state <= ST_STEP_WAIT;
          end
        end
        ST_DONE: begin
          if (w_accept && (w_cmd == CMD_CLEAR)) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_flushLast) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = w_cmdReady;
  assign enable_pipe_o = w_enable;
  assign pipe_flush_o  = w_inFlush;
  assign state_o       = r_state;
  assign halted_o      = r_halted;
  assign timeout_o     = r_timeout;
  assign cycle_count_o = w_count;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Scoreboard bench for pipeline_exec_ctrl. Two instances share the clock:
// dutA runs without a budget, dutB has MAX_CYCLES=5. The stimulus process
// drives directed commands and queues the hand-computed controller snapshot
// expected after each edge; a monitor pops and compares on the falling edge.
module tb_pipeline_exec_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_FLSH = 3'd5;

  localparam logic [1:0] C_RUN   = 2'b00;
  localparam logic [1:0] C_STEP  = 2'b01;
  localparam logic [1:0] C_STOP  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  typedef struct {
    int          dut;
    string       tag;
    logic [39:0] exp;
  } expT;

  logic clk = 1'b0;
  logic rst;
  logic cmdValidA, haltA, readyA, enA, flushA, haltedA, timeoutA;
  logic cmdValidB, haltB, readyB, enB, flushB, haltedB, timeoutB;
  logic [1:0]  cmdA, cmdB;
  logic [2:0]  stateA, stateB;
  logic [31:0] countA, countB;

  expT sbQ[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  pipeline_exec_ctrl #(.NB_CNT(32), .MAX_CYCLES(0), .FLUSH_CYCLES(2)) dutA (
    .clock_i(clk), .reset_i(rst), .cmd_valid_i(cmdValidA), .cmd_i(cmdA),
    .cmd_ready_o(readyA), .halt_wb_i(haltA), .enable_pipe_o(enA),
    .pipe_flush_o(flushA), .state_o(stateA), .halted_o(haltedA),
    .timeout_o(timeoutA), .cycle_count_o(countA)
  );

  pipeline_exec_ctrl #(.NB_CNT(32), .MAX_CYCLES(5), .FLUSH_CYCLES(2)) dutB (
    .clock_i(clk), .reset_i(rst), .cmd_valid_i(cmdValidB), .cmd_i(cmdB),
    .cmd_ready_o(readyB), .halt_wb_i(haltB), .enable_pipe_o(enB),
    .pipe_flush_o(flushB), .state_o(stateB), .halted_o(haltedB),
    .timeout_o(timeoutB), .cycle_count_o(countB)
  );

  // Drive one instance, keep the other quiet
  task automatic applyStimulus(input int d, input logic v, input logic [1:0] c, input logic h);
    cmdValidA = (d == 0) ? v : 1'b0;
    cmdA      = (d == 0) ? c : C_RUN;
    haltA     = (d == 0) ? h : 1'b0;
    cmdValidB = (d == 1) ? v : 1'b0;
    cmdB      = (d == 1) ? c : C_RUN;
    haltB     = (d == 1) ? h : 1'b0;
  endtask

  // Output decode taken straight from the state table
  task automatic pushExp(input int d, input string tag, input logic [2:0] st,
                         input logic hl, input logic tm, input logic [31:0] cn);
    expT  e;
    logic en, fl, rdy;
    en  = (st == S_RUN) || (st == S_EXEC);
    fl  = (st == S_FLSH);
    rdy = (st == S_IDLE) || (st == S_RUN) || (st == S_WAIT) || (st == S_DONE);
    e.dut = d;
    e.tag = tag;
    e.exp = {st, en, fl, rdy, hl, tm, cn};
    sbQ.push_back(e);
  endtask

  // One edge: inputs applied now are sampled at the next posedge, and the
  // expected post-edge snapshot is queued just after that edge
  task automatic cyc(input int d, input logic v, input logic [1:0] c, input logic h,
                     input string tag, input logic [2:0] st, input logic hl,
                     input logic tm, input logic [31:0] cn);
    applyStimulus(d, v, c, h);
    @(posedge clk);
    #1;
    pushExp(d, tag, st, hl, tm, cn);
  endtask

  task automatic checkOutput(input expT e);
    logic [39:0] act;
    act = (e.dut == 0) ? {stateA, enA, flushA, readyA, haltedA, timeoutA, countA}
                       : {stateB, enB, flushB, readyB, haltedB, timeoutB, countB};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got st=%0d en=%b fl=%b rdy=%b halted=%b timeout=%b cnt=%0d, expected st=%0d en=%b fl=%b rdy=%b halted=%b timeout=%b cnt=%0d",
               e.tag, e.dut, act[39:37], act[36], act[35], act[34], act[33], act[32], act[31:0],
               e.exp[39:37], e.exp[36], e.exp[35], e.exp[34], e.exp[33], e.exp[32], e.exp[31:0]);
    end
  endtask

  // Monitor: compares every queued expectation on the falling edge
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      while (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Directed stimulus with hand-computed snapshots
  initial begin
    rst = 1'b1;
    applyStimulus(0, 1'b0, C_RUN, 1'b0);
    @(posedge clk);
    #1;
    pushExp(0, "reset_a", S_IDLE, 1'b0, 1'b0, 32'd0);
    pushExp(1, "reset_b", S_IDLE, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;

    // RUN, halt marker on the tenth enabled edge
    cyc(0, 1'b1, C_RUN, 1'b0, "run_accept", S_RUN, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 9; i++)
      cyc(0, 1'b0, C_RUN, 1'b0, "run_count", S_RUN, 1'b0, 1'b0, 32'(i));
    cyc(0, 1'b0, C_RUN, 1'b1, "halt_done", S_DONE, 1'b1, 1'b0, 32'd10);
    cyc(0, 1'b1, C_RUN, 1'b0, "done_drops_run", S_DONE, 1'b1, 1'b0, 32'd10);
    cyc(0, 1'b0, C_RUN, 1'b1, "done_hold", S_DONE, 1'b1, 1'b0, 32'd10);

    // CLEAR from DONE; RUN held during the flush must not be taken
    cyc(0, 1'b1, C_CLEAR, 1'b0, "flush_enter", S_FLSH, 1'b0, 1'b0, 32'd0);
    cyc(0, 1'b1, C_RUN, 1'b0, "flush_blocks_run", S_FLSH, 1'b0, 1'b0, 32'd0);
    cyc(0, 1'b1, C_RUN, 1'b0, "flush_exit", S_IDLE, 1'b0, 1'b0, 32'd0);
    cyc(0, 1'b0, C_RUN, 1'b0, "idle_after_flush", S_IDLE, 1'b0, 1'b0, 32'd0);

    // Three single steps with gaps; halt ignored while paused
    cyc(0, 1'b1, C_STEP, 1'b0, "step1_exec", S_EXEC, 1'b0, 1'b0, 32'd0);
    cyc(0, 1'b0, C_RUN, 1'b0, "step1_wait", S_WAIT, 1'b0, 1'b0, 32'd1);
    cyc(0, 1'b0, C_RUN, 1'b0, "step_gap", S_WAIT, 1'b0, 1'b0, 32'd1);
    cyc(0, 1'b1, C_STEP, 1'b0, "step2_exec", S_EXEC, 1'b0, 1'b0, 32'd1);
    cyc(0, 1'b0, C_RUN, 1'b0, "step2_wait", S_WAIT, 1'b0, 1'b0, 32'd2);
    cyc(0, 1'b0, C_RUN, 1'b1, "wait_ignores_halt", S_WAIT, 1'b0, 1'b0, 32'd2);
    cyc(0, 1'b1, C_STEP, 1'b0, "step3_exec", S_EXEC, 1'b0, 1'b0, 32'd2);
    cyc(0, 1'b1, C_CLEAR, 1'b0, "exec_refuses_cmd", S_WAIT, 1'b0, 1'b0, 32'd3);
    cyc(0, 1'b1, C_CLEAR, 1'b0, "clr2_flush", S_FLSH, 1'b0, 1'b0, 32'd0);
    cyc(0, 1'b0, C_RUN, 1'b0, "clr2_flush2", S_FLSH, 1'b0, 1'b0, 32'd0);
    cyc(0, 1'b0, C_RUN, 1'b0, "clr2_idle", S_IDLE, 1'b0, 1'b0, 32'd0);

    // RUN, STOP after four enabled cycles, resume, then CLEAR mid-run
    cyc(0, 1'b1, C_RUN, 1'b0, "sr_run", S_RUN, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 3; i++)
      cyc(0, 1'b0, C_RUN, 1'b0, "sr_count", S_RUN, 1'b0, 1'b0, 32'(i));
    cyc(0, 1'b1, C_STOP, 1'b0, "sr_stop", S_WAIT, 1'b0, 1'b0, 32'd4);
    cyc(0, 1'b0, C_RUN, 1'b0, "sr_paused", S_WAIT, 1'b0, 1'b0, 32'd4);
    cyc(0, 1'b1, C_RUN, 1'b0, "sr_resume", S_RUN, 1'b0, 1'b0, 32'd4);
    cyc(0, 1'b0, C_RUN, 1'b0, "sr_run5", S_RUN, 1'b0, 1'b0, 32'd5);
    cyc(0, 1'b0, C_RUN, 1'b0, "sr_run6", S_RUN, 1'b0, 1'b0, 32'd6);
    cyc(0, 1'b1, C_CLEAR, 1'b0, "sr_clear", S_FLSH, 1'b0, 1'b0, 32'd0);
    cyc(0, 1'b0, C_RUN, 1'b0, "sr_flush2", S_FLSH, 1'b0, 1'b0, 32'd0);
    cyc(0, 1'b0, C_RUN, 1'b0, "sr_idle", S_IDLE, 1'b0, 1'b0, 32'd0);

    // Budget of five enabled cycles, no halt
    cyc(1, 1'b1, C_RUN, 1'b0, "bud_run", S_RUN, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 4; i++)
      cyc(1, 1'b0, C_RUN, 1'b0, "bud_count", S_RUN, 1'b0, 1'b0, 32'(i));
    cyc(1, 1'b0, C_RUN, 1'b0, "bud_timeout", S_DONE, 1'b0, 1'b1, 32'd5);
    cyc(1, 1'b0, C_RUN, 1'b0, "bud_hold", S_DONE, 1'b0, 1'b1, 32'd5);
    cyc(1, 1'b1, C_CLEAR, 1'b0, "bud_flush", S_FLSH, 1'b0, 1'b0, 32'd0);
    cyc(1, 1'b0, C_RUN, 1'b0, "bud_flush2", S_FLSH, 1'b0, 1'b0, 32'd0);
    cyc(1, 1'b0, C_RUN, 1'b0, "bud_idle", S_IDLE, 1'b0, 1'b0, 32'd0);

    // Halt on the same edge the budget expires: halt wins
    cyc(1, 1'b1, C_RUN, 1'b0, "tie_run", S_RUN, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 4; i++)
      cyc(1, 1'b0, C_RUN, 1'b0, "tie_count", S_RUN, 1'b0, 1'b0, 32'(i));
    cyc(1, 1'b0, C_RUN, 1'b1, "tie_halt_wins", S_DONE, 1'b1, 1'b0, 32'd5);

    // Reset mid-RUN on dutA also returns the finished dutB to idle
    cyc(0, 1'b1, C_RUN, 1'b0, "rst_run", S_RUN, 1'b0, 1'b0, 32'd0);
    cyc(0, 1'b0, C_RUN, 1'b0, "rst_run1", S_RUN, 1'b0, 1'b0, 32'd1);
    cyc(0, 1'b0, C_RUN, 1'b0, "rst_run2", S_RUN, 1'b0, 1'b0, 32'd2);
    rst = 1'b1;
    cyc(0, 1'b0, C_RUN, 1'b0, "reset_midrun", S_IDLE, 1'b0, 1'b0, 32'd0);
    pushExp(1, "reset_from_done", S_IDLE, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    cyc(0, 1'b0, C_RUN, 1'b0, "after_reset", S_IDLE, 1'b0, 1'b0, 32'd0);

    // Reset mid-FLUSH leaves no residual flush cycle
    cyc(0, 1'b1, C_CLEAR, 1'b0, "rf_flush", S_FLSH, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    cyc(0, 1'b0, C_RUN, 1'b0, "reset_midflush", S_IDLE, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    cyc(0, 1'b0, C_RUN, 1'b0, "no_residual_flush", S_IDLE, 1'b0, 1'b0, 32'd0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sbQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
